// File: rtl/seq_shifter.sv
// Multi-cycle shifter: SLL/SRL/SRA/ROR applied at most STEP bits per clock.
// Three-state control (IDLE/SHIFT/DONE) with back-to-back start and flush abort.
module seq_shifter #(
  parameter int N    = 32,
  parameter int STEP = 4,
  localparam int SW  = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          flush,
  input  logic [N-1:0]  A,
  input  logic [SW-1:0] shamt,
  input  logic [1:0]    mode,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [SW-1:0] STEP_W = SW'(STEP);
  localparam logic [SW:0]   N_W    = (SW+1)'(N);

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;

  state_e        state_q, state_d;
  logic [N-1:0]  work_q, work_d;
  logic [SW-1:0] rem_q, rem_d;
  logic [1:0]    mode_q, mode_d;
  logic [N-1:0]  out_q, out_d;

  logic [SW-1:0] k;
  logic [SW:0]   k_ext;
  logic [N-1:0]  shifted;

  // Step size for this cycle; k never exceeds rem so rem cannot underflow.
  always_comb begin
    k       = (rem_q < STEP_W) ? rem_q : STEP_W;
    k_ext   = {1'b0, k};
    shifted = work_q;
    case (mode_q)
      MODE_SLL: shifted = work_q << k;
      MODE_SRL: shifted = work_q >> k;
      MODE_SRA: shifted = $signed(work_q) >>> k;
      default:  shifted = (work_q >> k) | (work_q << (N_W - k_ext));
    endcase
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    out_d   = out_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        SHIFT: begin
          work_d = shifted;
          rem_d  = rem_q - k;
          if (rem_q <= STEP_W) state_d = DONE;
        end
        IDLE, DONE: begin
          if (start) begin
            work_d  = A;
            rem_d   = shamt;
            mode_d  = mode;
            state_d = (shamt != '0) ? SHIFT : DONE;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
      // Result is captured only when (re-)entering DONE.
      if (state_d == DONE) out_d = work_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      mode_q  <= 2'b00;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign out  = out_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter (N=32, STEP=4): directed vector table,
// hand-written multi-cycle corner sequences and randomized ops against a reference model.
module tb_seq_shifter;

  localparam int N    = 32;
  localparam int STEP = 4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [31:0] A;
  logic [4:0]  shamt;
  logic [1:0]  mode;
  logic        busy;
  logic        done;
  logic [31:0] out;

  int n_cmp = 0;
  int n_err = 0;

  seq_shifter #(.N(N), .STEP(STEP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .flush (flush),
    .A     (A),
    .shamt (shamt),
    .mode  (mode),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [4:0]  s;
    logic [1:0]  m;
    logic [31:0] exp_out;
    int          exp_lat;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic on the whole shift amount at once.
  function automatic logic [31:0] ref_shift(input logic [31:0] a, input int s, input logic [1:0] m);
    logic [63:0] dbl;
    case (m)
      2'b00:   return a << s;
      2'b01:   return a >> s;
      2'b10:   return $signed(a) >>> s;
      default: begin
        dbl = {a, a} >> s;
        return dbl[31:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(input int s);
    return 1 + (s + STEP - 1) / STEP;
  endfunction

  // Drives start for one edge, then follows the op to its done cycle (ends in that cycle).
  task automatic run_op(input logic [31:0] a, input logic [4:0] s, input logic [1:0] m,
                        input logic [31:0] exp_out, input int exp_lat, input string tag);
    logic [31:0] out_before;
    int cyc;
    out_before = out;
    A = a; shamt = s; mode = m; start = 1'b1;
    tick();
    start = 1'b0;
    A = $urandom; shamt = 5'($urandom); mode = 2'($urandom);
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      chk({tag, " busy"}, 32'(busy), 32'd1);
      chk({tag, " out_hold"}, out, out_before);
      tick();
      cyc++;
    end
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, " out"}, out, exp_out);
    chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
    $display("op %s: A=0x%08h shamt=%0d mode=%0d -> out=0x%08h lat=%0d", tag, a, s, m, out, cyc);
  endtask

  vec_t vecs[10];

  initial begin
    logic [31:0] prev;
    logic [31:0] ra;
    logic [4:0]  rs;
    logic [1:0]  rm;

    vecs[0] = '{32'h0000_0001,  5, 2'b00, 32'h0000_0020, 3};
    vecs[1] = '{32'h8000_0000, 31, 2'b10, 32'hFFFF_FFFF, 9};
    vecs[2] = '{32'h8000_0000, 31, 2'b01, 32'h0000_0001, 9};
    vecs[3] = '{32'h0000_00F1,  4, 2'b11, 32'h1000_000F, 2};
    vecs[4] = '{32'hDEAD_BEEF,  0, 2'b00, 32'hDEAD_BEEF, 1};
    vecs[5] = '{32'h1234_5678,  0, 2'b11, 32'h1234_5678, 1};
    vecs[6] = '{32'h7FFF_FFFF,  8, 2'b10, 32'h007F_FFFF, 3};
    vecs[7] = '{32'h0000_0001,  1, 2'b11, 32'h8000_0000, 2};
    vecs[8] = '{32'hFFFF_FFFF, 31, 2'b00, 32'h8000_0000, 9};
    vecs[9] = '{32'h8000_0010,  4, 2'b10, 32'hF800_0001, 2};

    rst_n = 1'b0; start = 1'b0; flush = 1'b0;
    A = 32'h0; shamt = 5'd0; mode = 2'b00;
    #12;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset out", out, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].s, vecs[i].m, vecs[i].exp_out, vecs[i].exp_lat, $sformatf("vec%0d", i));
      tick();
      chk($sformatf("vec%0d done_one_cycle", i), 32'(done), 32'd0);
    end

    // Back-to-back: second start driven during the first op's done cycle.
    run_op(32'h1, 5'd5, 2'b00, 32'h20, 3, "b2b_first");
    run_op(32'h3, 5'd1, 2'b00, 32'h6, 2, "b2b_second");
    tick();
    chk("b2b no extra done", 32'(done), 32'd0);

    // Start pulsed during SHIFT must be ignored.
    prev = out;
    A = 32'h0000_F000; shamt = 5'd12; mode = 2'b01; start = 1'b1;
    tick();
    A = 32'hFFFF_FFFF; shamt = 5'd0; mode = 2'b00;
    chk("ign c1 busy", 32'(busy), 32'd1);
    tick();
    start = 1'b0;
    chk("ign c2 busy", 32'(busy), 32'd1);
    chk("ign c2 done", 32'(done), 32'd0);
    chk("ign c2 out_hold", out, prev);
    tick();
    chk("ign c3 busy", 32'(busy), 32'd1);
    tick();
    chk("ign c4 done", 32'(done), 32'd1);
    chk("ign c4 out", out, 32'h0000_000F);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ign no extra done", 32'(done), 32'd0);
    end
    $display("op ignore_start: out=0x%08h", out);

    // Flush at cycle 3 of an SRL by 20.
    prev = out;
    A = 32'hABCD_0000; shamt = 5'd20; mode = 2'b01; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("flush c3 busy", 32'(busy), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush busy", 32'(busy), 32'd0);
    chk("flush done", 32'(done), 32'd0);
    chk("flush out", out, prev);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("flush no done", 32'(done), 32'd0);
    end
    chk("flush out after", out, prev);
    $display("op flush_mid: out=0x%08h", out);

    // Flush and start together: start dropped.
    flush = 1'b1; start = 1'b1; A = 32'h55; shamt = 5'd0; mode = 2'b00;
    tick();
    flush = 1'b0; start = 1'b0;
    chk("flush+start done", 32'(done), 32'd0);
    chk("flush+start out", out, prev);
    flush = 1'b1; start = 1'b1; A = 32'h55; shamt = 5'd8; mode = 2'b00;
    tick();
    flush = 1'b0; start = 1'b0;
    chk("flush+start busy", 32'(busy), 32'd0);
    tick();
    chk("flush+start later done", 32'(done), 32'd0);
    $display("op flush_start: out=0x%08h", out);

    // Reset asserted at cycle 2 of a 31-bit shift.
    run_op(32'h3, 5'd1, 2'b00, 32'h6, 2, "pre_reset");
    tick();
    A = 32'h1; shamt = 5'd31; mode = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("rst c2 busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst async busy", 32'(busy), 32'd0);
    chk("rst async done", 32'(done), 32'd0);
    chk("rst async out", out, 32'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("rst no done", 32'(done), 32'd0);
    end
    $display("op reset_mid: out=0x%08h", out);
    run_op(32'h0000_00F1, 5'd4, 2'b11, 32'h1000_000F, 2, "post_reset");
    tick();

    // Randomized ops, sometimes back-to-back.
    for (int i = 0; i < 150; i++) begin
      ra = $urandom;
      rs = 5'($urandom_range(0, 31));
      rm = 2'($urandom_range(0, 3));
      run_op(ra, rs, rm, ref_shift(ra, int'(rs), rm), ref_lat(int'(rs)), $sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) == 1) begin
        tick();
        chk("rnd idle done", 32'(done), 32'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 The block SHALL have parameter N, default 32, giving the data width (power of two, 8..64).
REQ-002 The block SHALL have parameter STEP, default 4, giving the maximum bits shifted per cycle (power of two, 1..N/2).
REQ-003 The block SHALL use local width SW = log2(N) for the shift amount.
REQ-004 The block SHALL have port clk, input, 1 bit: the only clock, with all state updated on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: request a new shift operation.
REQ-007 The block SHALL have port flush, input, 1 bit: synchronous abort of the current operation (pipeline flush).
REQ-008 The block SHALL have port A, input, N bits: the operand, sampled when start is accepted.
REQ-009 The block SHALL have port shamt, input, SW bits: the shift amount, sampled when start is accepted.
REQ-010 The block SHALL have port mode, input, 2 bits: 00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right), sampled when start is accepted.
REQ-011 The block SHALL have port busy, output, 1 bit: high while in state SHIFT.
REQ-012 The block SHALL have port done, output, 1 bit: high for exactly one cycle when the result is valid.
REQ-013 The block SHALL have port out, output, N bits: the result register.

Function
REQ-014 The block SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-015 start SHALL be accepted only in IDLE or DONE (this allows back-to-back operations); in SHIFT, start SHALL be ignored.
REQ-016 On acceptance, the block SHALL load work=A, rem=shamt and the latched mode, and move to SHIFT if shamt!=0 or to DONE if shamt==0.
REQ-017 In SHIFT, each edge SHALL shift work by k=min(rem,STEP) and set rem=rem-k; when rem<=STEP the block SHALL move to DONE, otherwise it stays in SHIFT.
REQ-018 SLL SHALL fill vacated bits with 0, SRL SHALL fill with 0, SRA SHALL fill with the original A[N-1], and ROR SHALL wrap bits shifted out at the LSB into the MSB.
REQ-019 The operation latency SHALL be exactly 1+ceil(shamt/STEP) cycles from the start-accept edge to done high; shamt=0 gives 1 cycle.
REQ-020 out SHALL update only on entry to DONE, take the value of work, and hold until the next entry to DONE or reset; out SHALL NOT change during SHIFT.
REQ-021 done SHALL be high only in state DONE; DONE SHALL go to IDLE on the next edge unless start is accepted, in which case it follows REQ-016.
REQ-022 flush SHALL move the block to IDLE from any state on the next edge; it SHALL suppress a pending done, leave out unchanged, and take priority over start in the same cycle.
REQ-023 All arithmetic SHALL stay within N bits and carry no sign extension beyond N; rem SHALL never underflow.
REQ-024 A, shamt and mode SHALL be ignored except on the start-accept cycle.

Reset
REQ-025 While rst_n=0, the block SHALL immediately set state=IDLE, busy=0, done=0, out=0, work=0, rem=0, independent of clk.
REQ-026 If reset is asserted mid-operation, the block SHALL discard that operation with no done; after rst_n rises, the first accepted start SHALL behave per REQ-016..019.

Verification (N=32, STEP=4; cycle numbers counted from the start-accept edge)
REQ-027 The bench SHALL check SLL: A=0x00000001, shamt=5 -> busy cycles 1-2, done at cycle 3, out=0x00000020.
REQ-028 The bench SHALL check SRA and SRL with A=0x80000000, shamt=31 -> done at cycle 9; SRA out=0xFFFFFFFF, SRL out=0x00000001.
REQ-029 The bench SHALL check ROR: A=0x000000F1, shamt=4 -> done at cycle 2, out=0x1000000F; and shamt=0 with any mode -> done at cycle 1, out=A.
REQ-030 The bench SHALL check back-to-back: a second start (SLL, A=0x3, shamt=1) asserted during the done cycle of the first -> accepted, second done at the cycle after that acceptance, out=0x6; a start pulsed during SHIFT -> ignored, with no extra done.
REQ-031 The bench SHALL check flush: flush at cycle 3 of an SRL by 20 -> IDLE next edge, busy=0, no done, out keeps its previous value; flush and start in the same cycle -> start is dropped.
REQ-032 The bench SHALL check reset: rst_n low at cycle 2 of a 31-bit shift -> outputs 0 asynchronously, with no done afterwards.
